quic_pkt_encoder: RTL and testbench

Parametrised, flow-controlled successor to the fixed-width QUIC encoder. It accepts payload words over a valid/ready handshake and assembles long- or short-header QUIC packets. Each packet carries a per-packet packet number (PN), and the protected block is encrypted with a PN-derived nonce. It sits between the payload source and the link framer as a 2-stage stallable pipeline at full throughput.

---
 rtl/quic_pkt_encoder_pkg.sv | 20 ++
 rtl/quic_pkt_encoder_if.sv | 29 ++
 rtl/quic_pkt_encoder_pn_counter.sv | 24 ++
 rtl/quic_pkt_encoder.sv | 75 +++++++
 tb/tb_quic_pkt_encoder.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/quic_pkt_encoder_pkg.sv
// Shared constants and the XOR protection helper for the QUIC packet encoder.
package quic_pkg;

  localparam logic [7:0]   HDR_LONG  = 8'hF0;
  localparam logic [7:0]   HDR_SHORT = 8'h40;
  localparam logic [7:0]   PAD_BYTE  = 8'hFF;

  localparam logic [127:0] DEF_KEY   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [95:0]  DEF_NONCE = 96'h0102030405060708090A0B0C;
  localparam logic [63:0]  DEF_DCID  = 64'h0123456789ABCDEF;
  localparam logic [63:0]  DEF_SCID  = 64'hFEDCBA9876543210;

  // Nonce is right-aligned under the 128-bit block; its top 32 bits see only the key.
  function automatic logic [127:0] quic_protect(input logic [127:0] p,
                                                input logic [127:0] key,
                                                input logic [95:0]  nonce);
    return p ^ key ^ {32'h0, nonce};
  endfunction

endpackage

// File: rtl/quic_pkt_encoder_if.sv
// Payload-in / packet-out handshake bundle; slave is the encoder side.
interface quic_pkt_encoder_if #(
  parameter int PAYLOAD_W = 134,
  parameter int PN_W      = 8
);
  localparam int OUT_W = PAYLOAD_W + 152;

  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 in_short;
  logic                 pn_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic [PN_W-1:0]      out_pn;
  logic                 pn_wrap;

  modport master (
    output in_valid, in_data, in_short, pn_clear, out_ready,
    input  in_ready, out_valid, out_data, out_pn, pn_wrap
  );

  modport slave (
    input  in_valid, in_data, in_short, pn_clear, out_ready,
    output in_ready, out_valid, out_data, out_pn, pn_wrap
  );

endinterface

// File: rtl/quic_pkt_encoder_pn_counter.sv
// Packet-number counter: clear beats increment, wrap pulse follows a wrapping accept.
module quic_pn_counter #(
  parameter int PN_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            accept,
  input  logic            clear,
  output logic [PN_W-1:0] pn,
  output logic            pn_wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pn      <= '0;
      pn_wrap <= 1'b0;
    end else begin
      pn_wrap <= accept & ~clear & (&pn);
      if (clear)       pn <= '0;
      else if (accept) pn <= pn + PN_W'(1);
    end
  end

endmodule

// File: rtl/quic_pkt_encoder.sv
// Two-stage stallable QUIC packet assembler: stage 1 captures payload+PN, stage 2 holds the packet.
module quic_pkt_encoder
  import quic_pkg::*;
#(
  parameter int           PAYLOAD_W = 134,
  parameter int           PN_W      = 8,
  parameter logic [127:0] KEY       = DEF_KEY,
  parameter logic [95:0]  NONCE     = DEF_NONCE,
  parameter logic [63:0]  DCID      = DEF_DCID,
  parameter logic [63:0]  SCID      = DEF_SCID
) (
  input  logic                clk,
  input  logic                rst_n,
  quic_pkt_encoder_if.slave   bus
);

  localparam int OUT_W  = PAYLOAD_W + 152;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] data;
    logic                 is_short;
    logic [PN_W-1:0]      pn;
  } s1_t;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1;
  logic             advance, accept;
  logic [PN_W-1:0]  pn;
  logic [127:0]     plain, cipher;
  logic [OUT_W-1:0] pkt;

  assign advance       = ~vld_pipe[2] | bus.out_ready;
  assign bus.in_ready  = ~vld_pipe[1] | advance;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = vld_pipe[2];

  quic_pn_counter #(.PN_W(PN_W)) u_pn (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (accept),
    .clear   (bus.pn_clear),
    .pn      (pn),
    .pn_wrap (bus.pn_wrap)
  );

  // Encryption sits between the stages so stage 2 registers the finished packet.
  assign plain  = {s1.is_short ? HDR_SHORT : HDR_LONG, DCID, s1.data[PAYLOAD_W-1 -: 56]};
  assign cipher = quic_protect(plain, KEY, NONCE ^ {{(96-PN_W){1'b0}}, s1.pn});
  assign pkt    = {cipher, s1.is_short ? 64'h0 : SCID, s1.pn, PAD_BYTE, s1.data[PAYLOAD_W-57:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      s1           <= '0;
      bus.out_data <= '0;
      bus.out_pn   <= '0;
    end else begin
      if (accept) begin
        s1          <= '{data: bus.in_data, is_short: bus.in_short, pn: pn};
        vld_pipe[1] <= 1'b1;
      end else if (advance) begin
        vld_pipe[1] <= 1'b0;
      end
      if (vld_pipe[1] & advance) begin
        vld_pipe[2]  <= 1'b1;
        bus.out_data <= pkt;
        bus.out_pn   <= s1.pn;
      end else if (bus.out_ready) begin
        vld_pipe[2]  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quic_pkt_encoder.sv
// Directed vectors, multi-cycle corner sequences and random traffic against a queue-based packet model.
module tb_quic_pkt_encoder;

  localparam int PW = 134;
  localparam int OW = PW + 152;
  localparam logic [127:0] KEY   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [95:0]  NONCE = 96'h0102030405060708090A0B0C;
  localparam logic [63:0]  DCID  = 64'h0123456789ABCDEF;
  localparam logic [63:0]  SCID  = 64'hFEDCBA9876543210;

  typedef struct {
    logic [PW-1:0] d;
    logic          s;
    logic [7:0]    hdr;
    logic [63:0]   scid;
    logic [7:0]    pn;
    logic          chk_c;
    logic [127:0]  c;
  } vec_t;

  typedef struct {
    logic [OW-1:0] d;
    logic [7:0]    pn;
    int            avail;
  } exp_t;

  typedef struct {
    logic          ov;
    logic [OW-1:0] od;
    logic [7:0]    opn;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rnd_rdy = 1'b0;
  logic fix_rdy = 1'b1;
  int   checks = 0, failures = 0, cyc = 0;

  exp_t       q[$];
  logic [7:0] out_log[$];
  logic [7:0] mpn;
  logic       wrap_exp;
  int         wrap_cnt;
  vec_t       vt[4];

  always #5 clk = ~clk;

  quic_pkt_encoder_if #(.PAYLOAD_W(PW), .PN_W(8)) bus();

  quic_pkt_encoder #(.PAYLOAD_W(PW), .PN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
  end

  function automatic logic [PW-1:0] rnd();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic logic [OW-1:0] model_pkt(input logic [PW-1:0] d, input logic s, input logic [7:0] pn);
    logic [127:0] p, c;
    p = {s ? 8'h40 : 8'hF0, DCID, d[PW-1 -: 56]};
    c = p ^ KEY ^ {32'h0, NONCE ^ {88'h0, pn}};
    return {c, s ? 64'h0 : SCID, pn, 8'hFF, d[PW-57:0]};
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called once per negedge; keeps the packet queue in step with the DUT.
  task automatic mon();
    logic ev, acc;
    if (!rst_n) begin
      q.delete();
      out_log.delete();
      mpn = 8'h00; wrap_exp = 1'b0; wrap_cnt = 0;
      chk("rst_out_valid", OW'(bus.out_valid), '0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_out_pn", OW'(bus.out_pn), '0);
      chk("rst_pn_wrap", OW'(bus.pn_wrap), '0);
    end else begin
      ev = (q.size() > 0) && (q[0].avail <= cyc);
      chk("in_ready", OW'(bus.in_ready), OW'((q.size() < 2) | bus.out_ready));
      chk("out_valid", OW'(bus.out_valid), OW'(ev));
      if (ev && bus.out_valid) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_pn", OW'(bus.out_pn), OW'(q[0].pn));
      end
      chk("pn_wrap", OW'(bus.pn_wrap), OW'(wrap_exp));
      if (bus.pn_wrap) wrap_cnt++;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        out_log.push_back(bus.out_pn);
        void'(q.pop_front());
      end
      acc = bus.in_valid & bus.in_ready;
      wrap_exp = acc & ~bus.pn_clear & (mpn == 8'hFF);
      if (acc) q.push_back('{model_pkt(bus.in_data, bus.in_short, mpn), mpn, cyc + 2});
      if (bus.pn_clear) mpn = 8'h00;
      else if (acc)     mpn = mpn + 8'h01;
    end
    cyc++;
  endtask

  task automatic step(input logic v, input logic [PW-1:0] d, input logic s, input logic clr,
                      output logic acc, output snap_t sn);
    bus.in_valid = v; bus.in_data = d; bus.in_short = s; bus.pn_clear = clr;
    @(negedge clk);
    sn.ov = bus.out_valid; sn.od = bus.out_data; sn.opn = bus.out_pn;
    acc = v & bus.in_ready;
    mon();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    logic a; snap_t sn;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, a, sn);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic chk_seq(input string nm, input int n);
    int mism;
    mism = 0;
    for (int i = 0; i < out_log.size() && i < n; i++) if (out_log[i] !== 8'(i)) mism++;
    chk({nm, "_count"}, OW'(out_log.size()), OW'(n));
    chk({nm, "_order"}, OW'(mism), '0);
  endtask

  initial begin
    logic acc, v, s, clr, pending;
    logic [PW-1:0] d;
    snap_t sn;
    int bad, nacc;

    vt[0].d = '1;             vt[0].s = 1'b0; vt[0].hdr = 8'hF0; vt[0].scid = SCID;  vt[0].pn = 8'd0;
    vt[0].chk_c = 1'b1;       vt[0].c = 128'hF1226622EF206526EBDABD907F5E391C;
    vt[1].d = rnd();          vt[1].s = 1'b1; vt[1].hdr = 8'h40; vt[1].scid = 64'h0; vt[1].pn = 8'd1;
    vt[1].chk_c = 1'b0;       vt[1].c = '0;
    vt[2].d = '0;             vt[2].s = 1'b0; vt[2].hdr = 8'hF0; vt[2].scid = SCID;  vt[2].pn = 8'd2;
    vt[2].chk_c = 1'b0;       vt[2].c = '0;
    vt[3].d = {67{2'b10}};    vt[3].s = 1'b1; vt[3].hdr = 8'h40; vt[3].scid = 64'h0; vt[3].pn = 8'd3;
    vt[3].chk_c = 1'b0;       vt[3].c = '0;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_short = 1'b0; bus.pn_clear = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // Directed vectors: accept at T, empty at T+1, packet at T+2.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vt[i].d, vt[i].s, 1'b0, acc, sn);
      chk("vec_accept", OW'(acc), OW'(1));
      step(1'b0, '0, 1'b0, 1'b0, acc, sn);
      chk("vec_lat_t1", OW'(sn.ov), '0);
      step(1'b0, '0, 1'b0, 1'b0, acc, sn);
      chk("vec_lat_t2", OW'(sn.ov), OW'(1));
      chk("vec_hdr", OW'(sn.od[OW-1 -: 8] ^ 8'h01), OW'(vt[i].hdr));
      chk("vec_scid", OW'(sn.od[OW-129 -: 64]), OW'(vt[i].scid));
      chk("vec_pn_field", OW'(sn.od[OW-193 -: 8]), OW'(vt[i].pn));
      chk("vec_pad", OW'(sn.od[OW-201 -: 8]), OW'(8'hFF));
      chk("vec_tail", OW'(sn.od[PW-57:0]), OW'(vt[i].d[PW-57:0]));
      chk("vec_out_pn", OW'(sn.opn), OW'(vt[i].pn));
      if (vt[i].chk_c) chk("vec_cipher", OW'(sn.od[OW-1 -: 128]), OW'(vt[i].c));
    end

    // 300 back-to-back packets through a PN wrap.
    reset_dut();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, rnd(), 1'($urandom_range(0, 1)), 1'b0, acc, sn);
      if (!acc) bad++;
    end
    idle(4);
    chk("b2b_in_ready_drops", OW'(bad), '0);
    chk_seq("b2b", 300);
    chk("b2b_wrap_count", OW'(wrap_cnt), OW'(1));

    // Downstream stall: two packets buffer, then release drains in order.
    reset_dut();
    fix_rdy = 1'b0;
    nacc = 0; d = rnd();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, d, 1'b0, 1'b0, acc, sn);
      if (acc) begin nacc++; d = rnd(); end
    end
    chk("stall_accepts", OW'(nacc), OW'(2));
    fix_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, d, 1'b1, 1'b0, acc, sn);
      if (acc) begin nacc++; d = rnd(); end
    end
    idle(4);
    chk_seq("stall", nacc);

    // pn_clear coincident with the accept of PN 7.
    reset_dut();
    for (int i = 0; i < 7; i++) step(1'b1, rnd(), 1'b0, 1'b0, acc, sn);
    step(1'b1, rnd(), 1'b0, 1'b1, acc, sn);
    step(1'b1, rnd(), 1'b1, 1'b0, acc, sn);
    idle(4);
    chk("clr_count", OW'(out_log.size()), OW'(9));
    if (out_log.size() == 9) begin
      chk("clr_pn7", OW'(out_log[7]), OW'(7));
      chk("clr_next_pn0", OW'(out_log[8]), '0);
    end
    chk("clr_no_wrap", OW'(wrap_cnt), '0);

    // Asynchronous reset with two packets in flight.
    reset_dut();
    fix_rdy = 1'b0;
    step(1'b1, rnd(), 1'b0, 1'b0, acc, sn);
    step(1'b1, rnd(), 1'b0, 1'b0, acc, sn);
    step(1'b0, '0, 1'b0, 1'b0, acc, sn);
    chk("pre_reset_valid", OW'(sn.ov), OW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", OW'(bus.out_valid), '0);
    chk("async_out_data", bus.out_data, '0);
    chk("async_out_pn", OW'(bus.out_pn), '0);
    fix_rdy = 1'b1;
    idle(2);
    rst_n = 1'b1;
    step(1'b1, rnd(), 1'b1, 1'b0, acc, sn);
    idle(3);
    chk_seq("post_reset", 1);

    // Random traffic, random backpressure, occasional pn_clear.
    reset_dut();
    rnd_rdy = 1'b1;
    pending = 1'b0; v = 1'b0; s = 1'b0; d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pending) begin
        v = ($urandom_range(0, 3) != 0);
        d = rnd();
        s = 1'($urandom_range(0, 1));
      end
      clr = ($urandom_range(0, 15) == 0);
      step(v, d, s, clr, acc, sn);
      pending = v & ~acc;
    end
    rnd_rdy = 1'b0;
    fix_rdy = 1'b1;
    idle(5);
    chk("drain_empty", OW'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
